// File: rtl/booth_multiplier_pkg.sv
// -----------------------------------------------------------------------------
// booth_multiplier_pkg
// Shared types and constants for the sequential radix-2 Booth multiplier.
//   DW           operand width (signed, two's complement)
//   DW_OUT       product width, always 2*DW
//   CW           width of the Booth step counter (counts 0..DW)
//   mult_state_t controller states IDLE/LOAD/CALC/DONE
//   booth_reg_t  working register set {a, q, q_1, m}
// Ports: none (package).
// -----------------------------------------------------------------------------
package booth_multiplier_pkg;

  localparam int DW     = 8;
  localparam int DW_OUT = 2 * DW;
  localparam int CW     = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } mult_state_t;

  // Plain encodings used by the controller state register.
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_LOAD = LOAD;
  localparam logic [1:0] ST_CALC = CALC;
  localparam logic [1:0] ST_DONE = DONE;

  // a and m carry one extra bit so that m = -2^(DW-1) can be subtracted
  // without overflowing the partial product.
  typedef struct packed {
    logic [DW:0]   a;
    logic [DW-1:0] q;
    logic          q_1;
    logic [DW:0]   m;
  } booth_reg_t;

  localparam booth_reg_t BOOTH_REG_CLR = '{
    a:   {(DW + 1){1'b0}},
    q:   {DW{1'b0}},
    q_1: 1'b0,
    m:   {(DW + 1){1'b0}}
  };

  // Sign-extend a DW-bit operand to the DW+1-bit accumulator width.
  function automatic logic [DW:0] sext_operand(input logic [DW-1:0] v);
    return {v[DW-1], v};
  endfunction

endpackage

// File: rtl/booth_multiplier_if.sv
// -----------------------------------------------------------------------------
// booth_multiplier_if
// Request/result bundle of the Booth multiplier.
//   i_start        start request (sampled only while the multiplier is idle)
//   i_multiplicand signed operand M
//   i_multiplier   signed operand Q
//   o_result       signed product, held until the next completion
//   o_ready        one-cycle pulse marking a new o_result
//   o_busy         high while an operation is in flight
// Modports: master (requester / downstream view), slave (multiplier).
// -----------------------------------------------------------------------------
interface booth_multiplier_if import booth_multiplier_pkg::*; ();

  logic              i_start;
  logic [DW-1:0]     i_multiplicand;
  logic [DW-1:0]     i_multiplier;
  logic [DW_OUT-1:0] o_result;
  logic              o_ready;
  logic              o_busy;

  modport master (
    output i_start, i_multiplicand, i_multiplier,
    input  o_result, o_ready, o_busy
  );

  modport slave (
    input  i_start, i_multiplicand, i_multiplier,
    output o_result, o_ready, o_busy
  );

endinterface

// File: rtl/booth_step.sv
// -----------------------------------------------------------------------------
// booth_step
// One combinational radix-2 Booth iteration:
//   {q[0], q_1} = 01 -> a + m, 10 -> a - m, otherwise a unchanged,
//   then arithmetic right shift of {a, q, q_1} by one bit.
// Ports:
//   cur  working registers before the step
//   nxt  working registers after the step (m passes through unchanged)
// -----------------------------------------------------------------------------
module booth_step import booth_multiplier_pkg::*; (
  input  booth_reg_t cur,
  output booth_reg_t nxt
);

  logic [DW:0] sum_s;

  // Add, subtract or keep the partial product depending on the Booth pair.
  always_comb begin
    sum_s = cur.a;
    case ({cur.q[0], cur.q_1})
      2'b01:   sum_s = cur.a + cur.m;
      2'b10:   sum_s = cur.a - cur.m;
      default: sum_s = cur.a;
    endcase
  end

  // Arithmetic shift: a's MSB is replicated, a's LSB moves into q, q's LSB into q_1.
  assign nxt = {sum_s[DW], sum_s[DW:1], sum_s[0], cur.q[DW-1:1], cur.q[0], cur.m};

endmodule

// File: rtl/booth_multiplier.sv
// -----------------------------------------------------------------------------
// booth_multiplier
// Sequential signed radix-2 Booth multiplier, one add/subtract per clock.
// A start seen in IDLE captures the operands; DW Booth steps follow in CALC,
// and DONE registers the product and pulses o_ready for one cycle, DW+1 edges
// after the start edge. o_ready/o_result feed the display stage directly.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous, active-low reset
//   bus  booth_multiplier_if.slave (i_start, operands, o_result, o_ready, o_busy)
// Optional build macro:
//   MULT_EARLY_ZERO_EN  when defined, a zero operand bypasses CALC via LOAD and
//                       the zero result appears 2 edges after the start edge.
// -----------------------------------------------------------------------------
module booth_multiplier import booth_multiplier_pkg::*; (
  input logic               clk,
  input logic               rst,
  booth_multiplier_if.slave bus
);

  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW - 1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST  = CW'(DW - 1);

  logic [1:0]        state_r;
  logic [1:0]        state_s;
  booth_reg_t        breg_r;
  booth_reg_t        breg_s;
  booth_reg_t        step_s;
  logic [CW-1:0]     count_r;
  logic [CW-1:0]     count_s;
  logic [DW_OUT-1:0] result_r;
  logic              ready_r;
  logic              busy_r;

`ifdef MULT_EARLY_ZERO_EN
  logic              zero_s;

  // Either operand zero means the product is zero without any Booth steps.
  always_comb begin
    if ((bus.i_multiplicand == {DW{1'b0}}) || (bus.i_multiplier == {DW{1'b0}})) begin
      zero_s = 1'b1;
    end else begin
      zero_s = 1'b0;
    end
  end
`endif

  booth_step u_step (
    .cur (breg_r),
    .nxt (step_s)
  );

  // Controller next-state and working-register update.
  always_comb begin
    state_s = state_r;
    breg_s  = breg_r;
    count_s = count_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.i_start) begin
          breg_s.a   = {(DW + 1){1'b0}};
          breg_s.q   = bus.i_multiplier;
          breg_s.q_1 = 1'b0;
          breg_s.m   = sext_operand(bus.i_multiplicand);
          count_s    = CNT_ZERO;
`ifdef MULT_EARLY_ZERO_EN
          if (zero_s) begin
            // Clearing q makes {a, q} an exact zero product for DONE.
            breg_s.q = {DW{1'b0}};
            state_s  = ST_LOAD;
          end else begin
            state_s  = ST_CALC;
          end
`else
          state_s = ST_CALC;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
`ifdef MULT_EARLY_ZERO_EN
        state_s = ST_DONE;
`else
        // Not entered in this build; return to IDLE without emitting a result.
        state_s = ST_IDLE;
`endif
      end
      ST_CALC: begin
        breg_s  = step_s;
        count_s = count_r + CNT_ONE;
        if (count_r == CNT_LAST) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_CALC;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        breg_s  = BOOTH_REG_CLR;
        count_s = CNT_ZERO;
      end
    endcase
  end

  // Controller state, working registers and step counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      breg_r  <= BOOTH_REG_CLR;
      count_r <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      breg_r  <= breg_s;
      count_r <= count_s;
    end
  end

  // Registered outputs: result/pulse on the DONE edge, busy tracks the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_r <= {DW_OUT{1'b0}};
      ready_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      if (state_r == ST_DONE) begin
        result_r <= {breg_r.a[DW-1:0], breg_r.q};
        ready_r  <= 1'b1;
      end else begin
        result_r <= result_r;
        ready_r  <= 1'b0;
      end
      busy_r <= (state_s != ST_IDLE);
    end
  end

  assign bus.o_result = result_r;
  assign bus.o_ready  = ready_r;
  assign bus.o_busy   = busy_r;

endmodule

// File: tb/tb_booth_multiplier.sv
// -----------------------------------------------------------------------------
// tb_booth_multiplier
// Directed self-checking bench for booth_multiplier. Inputs change and outputs
// are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_booth_multiplier;
  import booth_multiplier_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  booth_multiplier_if bus ();

  booth_multiplier dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef MULT_EARLY_ZERO_EN
  localparam int ZERO_LAT = 2;
`else
  localparam int ZERO_LAT = 9;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with i_start for exactly one edge (edge k).
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    bus.i_multiplicand = a;
    bus.i_multiplier   = b;
    bus.i_start        = 1'b1;
    tick();
    bus.i_start        = 1'b0;
  endtask

  // Edges after the start edge until o_ready is seen; 0 if it never appears.
  task automatic wait_ready(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.o_ready) begin
        n = i;
        break;
      end
    end
  endtask

  // Full operation: latency, product, busy at pulse, single-cycle pulse, hold.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input int lat);
    int n;
    start_op(a, b);
    chk({tag, "_busy"}, {31'd0, bus.o_busy}, 32'd1);
    wait_ready(n);
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_res"}, {16'd0, bus.o_result}, {16'd0, exp});
    tick();
    chk({tag, "_pulse"}, {31'd0, bus.o_ready}, 32'd0);
    chk({tag, "_hold"}, {16'd0, bus.o_result}, {16'd0, exp});
  endtask

  initial begin
    int n;
    int seen;
    int first;
    int last;
    int pulses;
    bus.i_start        = 1'b0;
    bus.i_multiplicand = 8'd0;
    bus.i_multiplier   = 8'd0;
    rst = 1'b0;
    tick();
    tick();
    chk("rst_result", {16'd0, bus.o_result}, 32'd0);
    chk("rst_ready", {31'd0, bus.o_ready}, 32'd0);
    chk("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    rst = 1'b1;
    tick();

    // Reset in the middle of CALC: outputs clear at once, no late pulse.
    start_op(8'd5, 8'd3);
    tick();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_result", {16'd0, bus.o_result}, 32'd0);
    chk("midrst_ready", {31'd0, bus.o_ready}, 32'd0);
    chk("midrst_busy", {31'd0, bus.o_busy}, 32'd0);
    tick();
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.o_ready || bus.o_busy) seen++;
    end
    chk("midrst_quiet", seen, 0);

    run_op("m7xn3", 8'd7, 8'hFD, 16'hFFEB, 9);
    run_op("n128xn128", 8'h80, 8'h80, 16'h4000, 9);
    run_op("p127xn128", 8'd127, 8'h80, 16'hC080, 9);

    // Second request during CALC with new operands must be ignored.
    start_op(8'd12, 8'd10);
    tick();
    tick();
    bus.i_multiplicand = 8'd99;
    bus.i_multiplier   = 8'd99;
    bus.i_start        = 1'b1;
    tick();
    tick();
    bus.i_start        = 1'b0;
    n = 0;
    for (int i = 5; i <= 20; i++) begin
      tick();
      if (bus.o_ready) begin
        n = i;
        break;
      end
    end
    chk("busy_ign_lat", n, 9);
    chk("busy_ign_res", {16'd0, bus.o_result}, 32'h0078);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.o_ready) seen++;
    end
    chk("busy_ign_single", seen, 0);

    // i_start held high: back-to-back -1 * -1 every DW+2 cycles.
    bus.i_multiplicand = 8'hFF;
    bus.i_multiplier   = 8'hFF;
    bus.i_start        = 1'b1;
    first  = 0;
    last   = 0;
    pulses = 0;
    seen   = 0;
    for (int i = 1; i <= 35; i++) begin
      tick();
      if (bus.o_ready) begin
        if (pulses == 0) first = i;
        else if ((i - last) != 10) seen++;
        if (bus.o_result !== 16'h0001) seen++;
        last = i;
        pulses++;
      end
    end
    bus.i_start = 1'b0;
    chk("b2b_first", first, 10);
    chk("b2b_count", pulses, 3);
    chk("b2b_gap_res", seen, 0);
    for (int i = 0; i < 12; i++) tick();

    run_op("zero_x55", 8'd0, 8'd55, 16'h0000, ZERO_LAT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
